// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : Registered N-bit ALU with valid/ready input handshake and a
//               multi-cycle shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_arg_A,
    input  logic [N-1:0] i_arg_B,
    output logic         o_valid,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    localparam logic [2:0] c_op_sub2 = 3'b000;
    localparam logic [2:0] c_op_add  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_sub  = 3'b101;
    localparam logic [2:0] c_op_mul  = 3'b110;
    localparam logic [2:0] c_op_shr  = 3'b111;

    localparam int              c_cnt_w = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);
    localparam logic [N:0]      c_n_val = (N + 1)'(N);

    logic [0:0]         r_state;
    logic [N-1:0]       r_result;
    logic [3:0]         r_status;
    logic               r_valid;
    logic [2*N-1:0]     r_mcand;
    logic [N-1:0]       r_mplier;
    logic [2*N-1:0]     r_prod;
    logic [c_cnt_w-1:0] r_count;
    logic               r_a_lt_b;

    logic [N+1:0]       w_ext_a;
    logic [N+1:0]       w_ext_b;
    logic [N+1:0]       w_wide;
    logic [N-1:0]       w_sc_res;
    logic               w_sc_ov;
    logic [2*N-1:0]     w_prod_next;
    logic [N-1:0]       w_fin_res;
    logic               w_fin_ov;
    logic               w_fin_lt;
    logic [3:0]         w_fin_status;
    logic               w_busy;

    assign w_busy   = (r_state == c_st_busy);
    assign o_ready  = ~w_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_status = r_status;

    // Arithmetic ops run on sign-extended operands so overflow is simply
    // the top three bits of the wide result disagreeing.
    always_comb begin
        w_ext_a  = {{2{i_arg_A[N-1]}}, i_arg_A};
        w_ext_b  = {{2{i_arg_B[N-1]}}, i_arg_B};
        w_wide   = '0;
        w_sc_res = '0;
        w_sc_ov  = 1'b0;
        case (i_op)
            c_op_sub2: w_wide = w_ext_a - {w_ext_b[N:0], 1'b0};
            c_op_add:  w_wide = w_ext_a + w_ext_b;
            c_op_sub:  w_wide = w_ext_a - w_ext_b;
            default:   w_wide = '0;
        endcase
        case (i_op)
            c_op_sub2, c_op_add, c_op_sub: begin
                w_sc_res = w_wide[N-1:0];
                w_sc_ov  = !((w_wide[N+1:N-1] == 3'b000) || (w_wide[N+1:N-1] == 3'b111));
            end
            c_op_and: w_sc_res = i_arg_A & i_arg_B;
            c_op_or:  w_sc_res = i_arg_A | i_arg_B;
            c_op_xor: w_sc_res = i_arg_A ^ i_arg_B;
            c_op_shr: w_sc_res = ({1'b0, i_arg_B} >= c_n_val) ? '0 : (i_arg_A >> i_arg_B);
            default:  w_sc_res = '0;
        endcase
    end

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    // Status is formed from whichever result is about to be registered.
    always_comb begin
        w_fin_res = w_busy ? w_prod_next[N-1:0] : w_sc_res;
        w_fin_ov  = w_busy ? (|w_prod_next[2*N-1:N]) : w_sc_ov;
        w_fin_lt  = w_busy ? r_a_lt_b : (i_arg_A < i_arg_B);
        w_fin_status = {^w_fin_res, w_fin_ov, (w_fin_res == '0), w_fin_lt};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= c_st_idle;
            r_result <= '0;
            r_status <= '0;
            r_valid  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_a_lt_b <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (i_valid) begin
                        if (i_op == c_op_mul) begin
                            r_mcand  <= {{N{1'b0}}, i_arg_A};
                            r_mplier <= i_arg_B;
                            r_prod   <= '0;
                            r_count  <= '0;
                            r_a_lt_b <= (i_arg_A < i_arg_B);
                            r_state  <= c_st_busy;
                        end else begin
                            r_result <= w_fin_res;
                            r_status <= w_fin_status;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                c_st_busy: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_result <= w_fin_res;
                        r_status <= w_fin_status;
                        r_valid  <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, clocked successor to the team's combinational ALU. Adds a registered N-bit datapath, a valid/ready input handshake, a one-cycle output valid pulse, eight opcodes including a multi-cycle shift-add multiplier, and a fully defined 4-bit status word. Sits between the operand/opcode decode stage and the result writeback stage of the datapath.

## Interface

- N, default 8: operand and result width; legal range ≥ 4.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_valid  in  1  request valid; op and operands are presented.
- o_ready  out  1  block can accept a request this cycle.
- i_op  in  3  opcode.
- i_arg_A  in  N  operand A.
- i_arg_B  in  N  operand B.
- o_valid  out  1  one-cycle pulse; o_result and o_status are new this cycle.
- o_result  out  N  result; held until the next result.
- o_status  out  4  {parity, overflow, zero, a_lt_b}; held with o_result.

## Operation

- Accept happens on an edge where i_valid && o_ready. i_op, i_arg_A and i_arg_B are captured at that edge. Later input changes have no effect on that operation.
- Opcodes:
  - 000: A − 2·B.
  - 001: A + B.
  - 010: A & B.
  - 011: A | B.
  - 100: A ^ B.
  - 101: A − B.
  - 110: A·B, unsigned, multi-cycle.
  - 111: A >> B, logical; result is 0 when B ≥ N.
- Width rules:
  - 000, 001 and 101 are computed at N+2 bits.
  - o_result is the low N bits of the computed value.
  - MUL produces 2N bits internally; o_result is the low N bits.
- o_status bits:
  - [0] a_lt_b: A < B, unsigned, on the captured operands. Valid for every op.
  - [1] zero: o_result == 0.
  - [2] overflow:
    - For 000, 001 and 101: the exact two's-complement result does not fit in N signed bits.
    - For 110: the upper N bits of the product are nonzero.
    - For all other ops: 0.
  - [3] parity: XOR-reduction of o_result (1 = odd number of ones).
- FSM has two states.
  - IDLE: o_ready = 1. Accepting op 110 → BUSY. Accepting any other op → stay in IDLE and register the result.
  - BUSY: o_ready = 0. An N-step shift-add runs, one multiplier bit per cycle. After step N → IDLE with the result registered.
  - i_valid is ignored while in BUSY.
- Reset:
  - After reset: o_result = 0, o_status = 0, o_valid = 0, o_ready = 1, FSM = IDLE.
  - Reset during BUSY aborts the multiply. No o_valid is produced for the aborted operation.
  - Reset has priority over an accept in the same cycle.

## Timing

- Single-cycle ops: accept at edge k → o_result, o_status and o_valid = 1 are visible after edge k. o_valid drops after edge k+1 unless another op is accepted at edge k+1.
- Back-to-back single-cycle ops: o_ready stays 1. One accept and one o_valid pulse per cycle; throughput 1 op per cycle.
- MUL: accept at edge k.
  - o_ready = 0 after edges k … k+N−1.
  - After edge k+N: result, status and o_valid = 1 are visible, and o_ready = 1.
  - The next request can therefore be accepted at edge k+N+1.
- o_result and o_status keep their last value whenever o_valid = 0, including while BUSY.

## Test plan

All values below use N = 8.

- Reset: assert i_reset for 2 cycles while i_valid = 1 → after release, o_result = 0x00, o_status = 0000, o_valid = 0, o_ready = 1, and no accept occurred during reset.
- Op 000:
  - A=20, B=3 → 0x0E, status 1000.
  - A=6, B=3 → 0x00, status 0010.
  - A=3, B=5 → 0xF9, status 0001.
  - A=0x7F, B=0xC0 → 0xFF, status 0101.
  - Each result with o_valid after the accept edge.
- Op 001 and op 111:
  - 001 with A=0x7F, B=0x01 → 0x80, status 1100.
  - 111 with A=0x80, B=3 → 0x10, status 1000.
  - 111 with A=0x80, B=9 → 0x00, status 0010.
- MUL, op 110:
  - A=15, B=17 → o_ready low for 8 cycles, then 0xFF with status 0001 after edge k+8.
  - A=16, B=16 → 0x00, status 0110.
  - i_valid held high throughout both → no extra accept while BUSY.
- Reset mid-multiply: accept MUL, assert i_reset at edge k+3 → no o_valid pulse, o_ready = 1 and outputs 0 after that edge; a following 001 request completes normally.
- Streaming: 6 consecutive 001 requests with i_valid high every cycle → 6 consecutive o_valid pulses with matching results; then a MUL followed immediately by a 010 request → the 010 request is accepted only after the MUL's o_valid.
